// File: rtl/wrap_counter.sv
// wrap_counter: WIDTH-bit up/down counter with load, terminal count and wrap pulse.
// Optional macro WRAP_COUNTER_SAT_EN selects saturating instead of modulo counting.
module wrap_counter #(
    parameter int          WIDTH   = 4,
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] RST_TRUNC = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;
    logic             w_at_bound;

    // The bound is the value a step in the current direction would leave.
    assign w_at_bound = up_dn ? (r_count == MAX_VAL) : (r_count == ZERO_VAL);

    // Next-state selection: load beats enable, enable beats hold.
    always_comb begin
        w_next_count = r_count;
        w_next_wrap  = 1'b0;
        if (load) begin
            w_next_count = load_val;
            w_next_wrap  = 1'b0;
        end else if (en) begin
`ifdef WRAP_COUNTER_SAT_EN
            if (w_at_bound) begin
                w_next_count = r_count;
                w_next_wrap  = 1'b1;
            end else begin
                w_next_count = up_dn ? (r_count + ONE_VAL) : (r_count - ONE_VAL);
                w_next_wrap  = 1'b0;
            end
`else
            w_next_count = up_dn ? (r_count + ONE_VAL) : (r_count - ONE_VAL);
            w_next_wrap  = w_at_bound;
`endif
        end else begin
            w_next_count = r_count;
            w_next_wrap  = 1'b0;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RST_TRUNC;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = w_at_bound;

endmodule

// File: tb/tb_wrap_counter.sv
// Scoreboard bench for wrap_counter: directed scenarios then random stimulus,
// checked against an arithmetic reference model.
module tb_wrap_counter;

    localparam int WIDTH   = 4;
    localparam int RST_VAL = 0;
    localparam int MODV    = 1 << WIDTH;
    localparam int MAXV    = MODV - 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    typedef struct {
        int cnt;
        bit wr;
        bit tcv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_count = 0;

    wrap_counter #(.WIDTH(WIDTH), .RST_VAL(32'(RST_VAL))) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge and predict the result.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l; load_val = WIDTH'(lv);
        x.wr = 1'b0;
        if (r) begin
            m_count = RST_VAL % MODV;
        end else if (l) begin
            m_count = lv % MODV;
        end else if (e) begin
`ifdef WRAP_COUNTER_SAT_EN
            if (u && m_count == MAXV) x.wr = 1'b1;
            else if (!u && m_count == 0) x.wr = 1'b1;
            else m_count = u ? m_count + 1 : m_count - 1;
`else
            if (u) begin
                x.wr = (m_count == MAXV);
                m_count = (m_count + 1) % MODV;
            end else begin
                x.wr = (m_count == 0);
                m_count = (m_count + MODV - 1) % MODV;
            end
`endif
        end
        x.cnt = m_count;
        x.tcv = u ? (m_count == MAXV) : (m_count == 0);
        exp_q.push_back(x);
    endtask

    // Monitor: compare DUT outputs just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (count !== WIDTH'(e.cnt)) begin
                    errors++;
                    $display("FAIL count: got %0d expected %0d at %0t", count, e.cnt, $time);
                end
                checks++;
                if (wrap !== e.wr) begin
                    errors++;
                    $display("FAIL wrap: got %0b expected %0b (count %0d) at %0t", wrap, e.wr, e.cnt, $time);
                end
                checks++;
                if (tc !== e.tcv) begin
                    errors++;
                    $display("FAIL tc: got %0b expected %0b (count %0d) at %0t", tc, e.tcv, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

        // Reset then continuous up count through two full wraps.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 1, 1, 0, 0);

        // Down wrap from 1.
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

        // Load priority over enable, reset priority over load.
        step(0, 0, 1, 1, 5);
        step(0, 1, 1, 1, 9);
        step(1, 1, 1, 1, 9);

        // Hold at 7.
        step(0, 0, 1, 1, 7);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

        // Reset in the middle of counting up.
        step(0, 0, 1, 1, 12);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);

        // Approach both bounds (saturation in the saturating build).
        step(0, 0, 1, 1, 14);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 8,
                 int'($urandom_range(0, MAXV)));
        end

        @(negedge clk);
        rst = 1'b0; en = 1'b0; load = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrap_counter.md
Name: wrap_counter

Overview:
- Synchronous binary counter, WIDTH bits wide, single clock domain.
- Counts up by one per clock when enabled; supports parallel load and down-count; flags terminal count.
- Generic building block for timers, address generators and test sequencing; no external dependencies.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- RST_VAL, 0, value loaded into count on reset; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst  input  1  synchronous active-high reset; sampled on posedge clk.
- en  input  1  count enable; 1 = step count this cycle.
- up_dn  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value written to count when load=1.
- count  output  WIDTH  current counter value; registered.
- tc  output  1  terminal count; combinational from count and up_dn.
- wrap  output  1  registered one-cycle pulse when a wrap (or saturation hit) occurred on the previous edge.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on posedge clk with rst=1: count <= RST_VAL, wrap <= 0. Reset overrides load and en.
- Priority per posedge, highest first: rst, load, en, hold.
- load=1 (rst=0): count <= load_val; wrap <= 0; en ignored that cycle.
- en=1, up_dn=1: count <= count + 1 modulo 2**WIDTH; 2**WIDTH-1 -> 0 sets wrap <= 1 for one cycle.
- en=1, up_dn=0: count <= count - 1 modulo 2**WIDTH; 0 -> 2**WIDTH-1 sets wrap <= 1 for one cycle.
- en=0, load=0: count holds; wrap <= 0.
- Latency: count reflects a step one clock after the edge that samples en=1.
- Continuous enable: after reset deassert, count reads 0,1,2,...,2**WIDTH-1,0,1,... on successive edges, with no skipped or repeated values.
- tc = 1 when (up_dn=1 and count=2**WIDTH-1) or (up_dn=0 and count=0); independent of en.
- Reset mid-count: the next edge with rst=1 forces RST_VAL regardless of the current value.
- All arithmetic is unsigned WIDTH-bit; no carry output beyond wrap.
- No X propagation: count is defined from the first reset onward.

Optional Feature:
- Macro: WRAP_COUNTER_SAT_EN.
- Defined: saturating mode. Up-count holds at 2**WIDTH-1 and down-count holds at 0 instead of wrapping. wrap pulses on the edge where a step is requested while already at the bound (the saturation-hit indication). load is unaffected.
- Undefined: modulo wrap-around as described in Behaviour (default build).

Test Plan:
- Reset then run: rst=1 for 2 cycles, then rst=0, en=1, up_dn=1 for 32 cycles (WIDTH=4) -> count 0..15,0..15 in order; wrap high exactly after the 15->0 transitions.
- Down wrap: load load_val=1, then en=1, up_dn=0 for 3 cycles -> count 1,0,15,14; tc=1 while count=0; wrap pulses after 0->15.
- Load priority: count=5, assert load=1 with load_val=9 and en=1 -> count=9 next cycle (no increment); assert rst=1 together with load -> count=RST_VAL.
- Hold: count=7, en=0 for 4 cycles -> count stays 7; wrap=0; tc=0 with up_dn=1.
- Mid-operation reset: count=12 counting up, pulse rst=1 for one cycle -> count=0 on the next edge; counting resumes 1,2,... after release.
- With WRAP_COUNTER_SAT_EN defined: count=14, en=1, up_dn=1 for 3 cycles -> 15,15,15; wrap pulses on the two held steps; count never returns to 0.
